sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Parametrised monochrome-ROM image blitter that paints one of `NUM_IMG` stored images into the `vga_adapter` frame buffer at a programmable origin. A control FSM raster-scans the image, drives the shared ROM address bus, compensates ROM read latency, maps each bit to a foreground/background colour, clips off-screen pixels and reports completion with a `start`/`busy`/`done` handshake. It sits between game logic (choice/player select) and the adapter's `x`/`y`/`colour`/`plot` port.

## Interface
- `SCREEN_W`, 160: frame-buffer width in pixels
- `SCREEN_H`, 120: frame-buffer height in pixels
- `IMG_W`, 160: image width in pixels
- `IMG_H`, 120: image height in pixels
- `NUM_IMG`, 3: number of image ROMs; `rom_q` has one bit per image
- `COLOUR_W`, 3: colour width
- `ROM_LAT`, 1: ROM read latency in cycles (1..3)
- `TRANSPARENT_BG`, 0: 1 = background pixels are not plotted
- Derived: `X_W`=clog2(SCREEN_W), `Y_W`=clog2(SCREEN_H), `A_W`=clog2(IMG_W*IMG_H), `S_W`=max(1,clog2(NUM_IMG))

Ports:
- `CLOCK_50` in 1: sole clock
- `reset_n` in 1: synchronous, active-low reset
- `start` in 1: request a blit; sampled only in IDLE
- `img_sel` in `S_W`: image index, latched on accepted start
- `x0` in `X_W`, `y0` in `Y_W`: screen origin of image pixel (0,0), latched on start
- `fg_colour`, `bg_colour` in `COLOUR_W`: colours for ROM bit 0 / bit 1, latched on start
- `rom_addr` out `A_W`: shared address to all image ROMs
- `rom_q` in `NUM_IMG`: ROM data, bit i from image i
- `x` out `X_W`, `y` out `Y_W`, `colour` out `COLOUR_W`, `plot` out 1: to `vga_adapter`
- `busy` out 1: blit in progress
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: `start`=1 latches `img_sel`, `x0`, `y0`, colours; go SCAN. `img_sel` ≥ `NUM_IMG` is treated as 0.
- SCAN: image counters `ix` (0..IMG_W-1), `iy` (0..IMG_H-1) advance row-major, one pixel per cycle; `rom_addr` = linear counter, incremented by 1, never multiplied; `rom_addr` = iy*IMG_W+ix always. `ix` wraps to 0 at IMG_W-1 (not past it) and `iy` increments. After pixel (IMG_W-1, IMG_H-1) go DRAIN.
- DRAIN: `ROM_LAT` cycles so the final pixel reaches the output; then DONE.
- DONE: `done`=1 for one cycle; back to IDLE.
- Pixel pipeline: screen coords `x0+ix`, `y0+iy` computed at `X_W+1`/`Y_W+1` bits, delayed `ROM_LAT` cycles alongside a valid bit, aligned with `rom_q[img_sel]`.
- Output: bit 0 → `fg_colour`; bit 1 → `bg_colour`. `plot`=1 when valid, not clipped, and not (bit 1 and `TRANSPARENT_BG`).
- Clipping: sum ≥ `SCREEN_W` or ≥ `SCREEN_H` suppresses `plot`; the scan still visits every pixel, so duration is constant.
- `start` during SCAN/DRAIN/DONE is ignored; latched inputs are unaffected by input changes mid-blit.

## Timing
- Reset (next edge, any state, including mid-blit): state IDLE; `rom_addr`, `x`, `y`, `colour`, `plot`, `busy`, `done` = 0; pipeline valid bits cleared.
- `start` accepted at edge N → `busy`=1 and `rom_addr`=0 from cycle N+1.
- Pixel k (0-based): `rom_addr`=k in cycle N+1+k; `x`/`y`/`colour`/`plot` registered, valid in cycle N+1+k+`ROM_LAT`.
- `done` in cycle N+1+IMG_W*IMG_H+`ROM_LAT`; `busy` high through that cycle, low after.
- Earliest back-to-back: `start` held high re-accepted in the first IDLE cycle after DONE.
- `plot`=0 whenever `busy`=0.

## Structure
- Package `gra_pkg`: `SCREEN_W`/`SCREEN_H` defaults (160x120), colour constants (`COL_BLACK`=3'b000, `COL_GREEN`=3'b010, `COL_WHITE`=3'b111), FSM state enum.
- Sub-module `blit_scan_counter`: `ix`/`iy`/linear-address counters with wrap and last-pixel flag; FSM, delay line and colour mux stay in `sprite_blitter`.

## Test plan
- Defaults, `img_sel`=1, origin (0,0), ROM1 = address LSB: 19200 plots; pixel 0 fg, pixel 1 bg; pixel 159 at (159,0), pixel 160 at (0,1); `done` exactly 19202 cycles after start edge.
- IMG 8x4, origin (156,118): only 4x2=8 plots, all with x≥156, y≥118; `done` timing unchanged (8*4+1+ROM_LAT).
- `TRANSPARENT_BG`=1, ROM all 1s: zero plots, `done` still pulses once.
- `ROM_LAT`=3: colour/coords of pixel k appear exactly 3 cycles after `rom_addr`=k; no skew against a reference model.
- `start` pulsed and `img_sel`/`fg_colour` changed mid-SCAN: no restart, output uses latched values; `start` held high yields second blit starting the cycle after `done`.
- `reset_n`=0 for one cycle mid-SCAN: next cycle `busy`, `plot`, `done`, `rom_addr` = 0; fresh `start` then completes a full-length blit.

Source files
------------

// File: rtl/gra_pkg.sv
// Shared graphics constants, blitter FSM state encoding and small helpers.
package gra_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } blit_state_t;

  // Keeps derived widths legal when a dimension collapses to a single value.
  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/blit_scan_counter.sv
// Row-major image scan: column/row counters plus a linear ROM address that is
// only ever incremented, so it always equals iy*IMG_W+ix without a multiplier.
module blit_scan_counter
  import gra_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int IX_W  = 8,
  parameter int IY_W  = 7,
  parameter int A_W   = 15
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            advance,
  output logic [IX_W-1:0] ix,
  output logic [IY_W-1:0] iy,
  output logic [A_W-1:0]  addr,
  output logic            last
);

  logic row_end;

  assign row_end = (ix == IX_W'(IMG_W - 1));
  assign last    = row_end && (iy == IY_W'(IMG_H - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n || clear) begin
      ix   <= '0;
      iy   <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last) begin
        ix   <= '0;
        iy   <= '0;
        addr <= '0;
      end else if (row_end) begin
        ix   <= '0;
        iy   <= iy + 1'b1;
        addr <= addr + 1'b1;
      end else begin
        ix   <= ix + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Paints one monochrome ROM image into the frame buffer at (x0,y0). rom_q must
// present the bit for rom_addr ROM_LAT-1 cycles later; the output register is the last stage.
module sprite_blitter
  import gra_pkg::*;
#(
  parameter int SCREEN_W       = DEF_SCREEN_W,
  parameter int SCREEN_H       = DEF_SCREEN_H,
  parameter int IMG_W          = 160,
  parameter int IMG_H          = 120,
  parameter int NUM_IMG        = 3,
  parameter int COLOUR_W       = 3,
  parameter int ROM_LAT        = 1,
  parameter int TRANSPARENT_BG = 0,
  localparam int X_W  = $clog2(SCREEN_W),
  localparam int Y_W  = $clog2(SCREEN_H),
  localparam int A_W  = $clog2(IMG_W * IMG_H),
  localparam int S_W  = max1($clog2(NUM_IMG))
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                start,
  input  logic [S_W-1:0]      img_sel,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic [A_W-1:0]      rom_addr,
  input  logic [NUM_IMG-1:0]  rom_q,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int IX_W = max1($clog2(IMG_W));
  localparam int IY_W = max1($clog2(IMG_H));
  localparam int D_W  = max1($clog2(ROM_LAT));
  localparam int PW   = 1 + (X_W + 1) + (Y_W + 1);

  blit_state_t         state;
  logic [D_W-1:0]      drain_cnt;
  logic [S_W-1:0]      sel_q;
  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;
  logic [COLOUR_W-1:0] fg_q;
  logic [COLOUR_W-1:0] bg_q;
  logic                accept;
  logic [IX_W-1:0]     ix;
  logic [IY_W-1:0]     iy;
  logic                last;
  logic [PW-1:0]       cur_p0;
  logic [PW-1:0]       tap;
  logic                tap_vld;
  logic [X_W:0]        tap_sx;
  logic [Y_W:0]        tap_sy;
  logic                pix_bit;

  function automatic logic on_screen(input logic [X_W:0] sx, input logic [Y_W:0] sy);
    return (32'(sx) < SCREEN_W) && (32'(sy) < SCREEN_H);
  endfunction

  assign accept = (state == ST_IDLE) && start;

  blit_scan_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .IX_W  (IX_W),
    .IY_W  (IY_W),
    .A_W   (A_W)
  ) u_scan (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .clear    (accept),
    .advance  (state == ST_SCAN),
    .ix       (ix),
    .iy       (iy),
    .addr     (rom_addr),
    .last     (last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_SCAN;
            busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (last) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == D_W'(ROM_LAT - 1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Blit parameters are frozen at acceptance so mid-blit input changes are harmless.
  always_ff @(posedge CLOCK_50) begin
    if (accept) begin
      sel_q <= (32'(img_sel) >= NUM_IMG) ? '0 : img_sel;
      x0_q  <= x0;
      y0_q  <= y0;
      fg_q  <= fg_colour;
      bg_q  <= bg_colour;
    end
  end

  // Stage p0: screen coordinates of the pixel currently addressed
  assign cur_p0 = {(state == ST_SCAN),
                   {1'b0, x0_q} + (X_W + 1)'(ix),
                   {1'b0, y0_q} + (Y_W + 1)'(iy)};

  // Delay stages p1..: ROM_LAT-1 registers so coordinates meet their rom_q bit
  if (ROM_LAT > 1) begin : g_dly
    logic [PW-1:0] dly_p [1:ROM_LAT-1];

    always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
        for (int i = 1; i < ROM_LAT; i++) dly_p[i] <= '0;
      end else begin
        dly_p[1] <= cur_p0;
        for (int i = 2; i < ROM_LAT; i++) dly_p[i] <= dly_p[i-1];
      end
    end

    assign tap = dly_p[ROM_LAT-1];
  end else begin : g_nodly
    assign tap = cur_p0;
  end

  assign {tap_vld, tap_sx, tap_sy} = tap;
  assign pix_bit = rom_q[sel_q];

  // Output stage: colour mux, clipping and transparency
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      x      <= tap_sx[X_W-1:0];
      y      <= tap_sy[Y_W-1:0];
      colour <= pix_bit ? bg_q : fg_q;
      plot   <= tap_vld && on_screen(tap_sx, tap_sy) &&
                !(pix_bit && (TRANSPARENT_BG != 0));
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Three blitter instances (full-size, small ROM_LAT=3, small transparent ROM_LAT=2)
// driven by directed and random blits and checked against a pixel-list model.
module tb_sprite_blitter;
  import gra_pkg::*;

  typedef struct {
    int c;
    int x;
    int y;
    int col;
  } pix_t;

  bit CLOCK_50 = 1'b0;
  logic reset_n;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // instance A: defaults; B: 8x4 ROM_LAT=3; C: 8x4 ROM_LAT=2 transparent
  logic a_start, b_start, c_start;
  logic [1:0] a_sel, b_sel, c_sel;
  logic [7:0] a_x0, b_x0, c_x0, a_x, b_x, c_x;
  logic [6:0] a_y0, b_y0, c_y0, a_y, b_y, c_y;
  logic [2:0] a_fg, b_fg, c_fg, a_bg, b_bg, c_bg, a_col, b_col, c_col;
  logic [14:0] a_addr;
  logic [4:0] b_addr, c_addr;
  logic [2:0] a_rom_q, b_rom_q, c_rom_q;
  logic a_plot, b_plot, c_plot, a_busy, b_busy, c_busy, a_done, b_done, c_done;

  bit b_mem [0:2][0:31];
  bit c_mem [0:2][0:31];
  logic [4:0] b_a1, b_a2, c_a1;
  pix_t a_obs[$], b_obs[$], c_obs[$];
  pix_t exp_q[$];

  function automatic bit rom_a(input int img, input int a);
    case (img)
      0:       return ((a ^ (a >> 5)) % 3) == 0;
      1:       return a[0];
      default: return a[4];
    endcase
  endfunction

  assign a_rom_q = {rom_a(2, int'(a_addr)), rom_a(1, int'(a_addr)), rom_a(0, int'(a_addr))};
  always @(posedge CLOCK_50) begin
    b_a1 <= b_addr;
    b_a2 <= b_a1;
    c_a1 <= c_addr;
  end
  assign b_rom_q = {b_mem[2][b_a2], b_mem[1][b_a2], b_mem[0][b_a2]};
  assign c_rom_q = {c_mem[2][c_a1], c_mem[1][c_a1], c_mem[0][c_a1]};

  always @(negedge CLOCK_50) begin
    if (a_plot === 1'b1) a_obs.push_back('{cyc, int'(a_x), int'(a_y), int'(a_col)});
    if (b_plot === 1'b1) b_obs.push_back('{cyc, int'(b_x), int'(b_y), int'(b_col)});
    if (c_plot === 1'b1) c_obs.push_back('{cyc, int'(c_x), int'(c_y), int'(c_col)});
  end

  sprite_blitter u_a (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(a_start), .img_sel(a_sel),
    .x0(a_x0), .y0(a_y0), .fg_colour(a_fg), .bg_colour(a_bg), .rom_addr(a_addr),
    .rom_q(a_rom_q), .x(a_x), .y(a_y), .colour(a_col), .plot(a_plot),
    .busy(a_busy), .done(a_done));

  sprite_blitter #(.IMG_W(8), .IMG_H(4), .ROM_LAT(3)) u_b (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(b_start), .img_sel(b_sel),
    .x0(b_x0), .y0(b_y0), .fg_colour(b_fg), .bg_colour(b_bg), .rom_addr(b_addr),
    .rom_q(b_rom_q), .x(b_x), .y(b_y), .colour(b_col), .plot(b_plot),
    .busy(b_busy), .done(b_done));

  sprite_blitter #(.IMG_W(8), .IMG_H(4), .ROM_LAT(2), .TRANSPARENT_BG(1)) u_c (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(c_start), .img_sel(c_sel),
    .x0(c_x0), .y0(c_y0), .fg_colour(c_fg), .bg_colour(c_bg), .rom_addr(c_addr),
    .rom_q(c_rom_q), .x(c_x), .y(c_y), .colour(c_col), .plot(c_plot),
    .busy(c_busy), .done(c_done));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int w, input int sel, input int x0, input int y0,
                        input int fg, input int bg, input logic st);
    case (w)
      0: begin a_sel = 2'(sel); a_x0 = 8'(x0); a_y0 = 7'(y0); a_fg = 3'(fg); a_bg = 3'(bg); a_start = st; end
      1: begin b_sel = 2'(sel); b_x0 = 8'(x0); b_y0 = 7'(y0); b_fg = 3'(fg); b_bg = 3'(bg); b_start = st; end
      default: begin c_sel = 2'(sel); c_x0 = 8'(x0); c_y0 = 7'(y0); c_fg = 3'(fg); c_bg = 3'(bg); c_start = st; end
    endcase
  endtask

  task automatic set_start(input int w, input logic st);
    case (w)
      0: a_start = st;
      1: b_start = st;
      default: c_start = st;
    endcase
  endtask

  function automatic logic sig_done(input int w);
    return (w == 0) ? a_done : (w == 1) ? b_done : c_done;
  endfunction
  function automatic logic sig_busy(input int w);
    return (w == 0) ? a_busy : (w == 1) ? b_busy : c_busy;
  endfunction
  function automatic logic [14:0] sig_addr(input int w);
    return (w == 0) ? a_addr : (w == 1) ? 15'(b_addr) : 15'(c_addr);
  endfunction

  task automatic start_blit(input int w, input int sel, input int x0, input int y0,
                            input int fg, input int bg, input bit hold, output int s);
    @(negedge CLOCK_50);
    set_in(w, sel, x0, y0, fg, bg, 1'b1);
    @(posedge CLOCK_50);
    #1;
    s = cyc;
    if (!hold) set_start(w, 1'b0);
  endtask

  task automatic wait_done(input int w, input int budget, output int d);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (sig_done(w) === 1'b1) begin
        found = 1;
        break;
      end
    end
    d = cyc;
    chk($sformatf("done_seen[%0d]", w), 64'(found), 64'd1);
  endtask

  // Expected plot list comes straight from the pixel rules; then one cycle on
  // the done pulse and busy must both have dropped.
  task automatic check_blit(input int w, input string tag, input int sel, input int x0,
                            input int y0, input int fg, input int bg, input int s, input int d);
    int iw, ih, lat, tbg, es, mism, first, n;
    pix_t obs[$];
    iw  = (w == 0) ? 160 : 8;
    ih  = (w == 0) ? 120 : 4;
    lat = (w == 0) ? 1 : (w == 1) ? 3 : 2;
    tbg = (w == 2) ? 1 : 0;
    es  = (sel >= 3) ? 0 : sel;
    exp_q.delete();
    for (int py = 0; py < ih; py++) begin
      for (int px = 0; px < iw; px++) begin
        int k = py * iw + px;
        bit b = (w == 0) ? rom_a(es, k) : (w == 1) ? b_mem[es][k] : c_mem[es][k];
        int sx = x0 + px;
        int sy = y0 + py;
        if (sx < 160 && sy < 120 && !(b && tbg != 0))
          exp_q.push_back('{s + k + lat, sx, sy, b ? bg : fg});
      end
    end
    case (w)
      0: begin obs = a_obs; a_obs.delete(); end
      1: begin obs = b_obs; b_obs.delete(); end
      default: begin obs = c_obs; c_obs.delete(); end
    endcase
    chk({tag, " done_cycle"}, 64'(d), 64'(s + iw * ih + lat));
    chk({tag, " plot_count"}, 64'(obs.size()), 64'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    mism = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (obs[i].c != exp_q[i].c || obs[i].x != exp_q[i].x ||
          obs[i].y != exp_q[i].y || obs[i].col != exp_q[i].col) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    if (mism != 0)
      $display("  %s first bad plot %0d: got t%0d (%0d,%0d) c%0d want t%0d (%0d,%0d) c%0d",
               tag, first, obs[first].c, obs[first].x, obs[first].y, obs[first].col,
               exp_q[first].c, exp_q[first].x, exp_q[first].y, exp_q[first].col);
    chk({tag, " plot_mismatches"}, 64'(mism), 64'd0);
    @(posedge CLOCK_50);
    #1;
    chk({tag, " done_one_cycle"}, 64'(sig_done(w)), 64'd0);
    chk({tag, " busy_after"}, 64'(sig_busy(w)), 64'd0);
  endtask

  initial begin
    int s, d, s2, d2, sel, x0, y0, fg, bg;
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    set_in(1, 0, 0, 0, 0, 0, 1'b0);
    set_in(2, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 32; j++) begin
        b_mem[i][j] = 1'($urandom);
        c_mem[i][j] = 1'($urandom);
      end
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst busy", 64'(a_busy), 64'd0);
    chk("rst done", 64'(a_done), 64'd0);
    chk("rst plot", 64'(a_plot), 64'd0);
    chk("rst rom_addr", 64'(a_addr), 64'd0);
    chk("rst x", 64'(a_x), 64'd0);
    chk("rst y", 64'(a_y), 64'd0);
    chk("rst colour", 64'(a_col), 64'd0);
    chk("rst b_plot", 64'(b_plot), 64'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;

    // full-size image 1 (address LSB) at the origin
    start_blit(0, 1, 0, 0, COL_GREEN, COL_WHITE, 0, s);
    chk("a busy_first", 64'(a_busy), 64'd1);
    chk("a addr_first", 64'(a_addr), 64'd0);
    wait_done(0, 30000, d);
    chk("a n19200", 64'(a_obs.size()), 64'd19200);
    chk("a px0 fg", 64'(a_obs[0].col), 64'(COL_GREEN));
    chk("a px1 bg", 64'(a_obs[1].col), 64'(COL_WHITE));
    chk("a px159 x", 64'(a_obs[159].x), 64'd159);
    chk("a px159 y", 64'(a_obs[159].y), 64'd0);
    chk("a px160 x", 64'(a_obs[160].x), 64'd0);
    chk("a px160 y", 64'(a_obs[160].y), 64'd1);
    chk("a done_19202", 64'(d - s + 1), 64'd19202);
    check_blit(0, "a_full", 1, 0, 0, COL_GREEN, COL_WHITE, s, d);

    // one-cycle reset mid-scan, then a fresh full blit
    start_blit(0, 0, 0, 0, COL_GREEN, COL_BLACK, 0, s);
    repeat (100) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    @(posedge CLOCK_50);
    #1;
    chk("mid_rst busy", 64'(a_busy), 64'd0);
    chk("mid_rst plot", 64'(a_plot), 64'd0);
    chk("mid_rst done", 64'(a_done), 64'd0);
    chk("mid_rst addr", 64'(a_addr), 64'd0);
    reset_n = 1'b1;
    a_obs.delete();
    x0 = $urandom_range(0, 40);
    y0 = $urandom_range(0, 30);
    start_blit(0, 0, x0, y0, COL_WHITE, COL_GREEN, 0, s);
    wait_done(0, 30000, d);
    check_blit(0, "a_after_rst", 0, x0, y0, COL_WHITE, COL_GREEN, s, d);

    // clipped corner origin
    start_blit(1, 1, 156, 118, COL_WHITE, COL_GREEN, 0, s);
    wait_done(1, 200, d);
    chk("b_corner n8", 64'(b_obs.size()), 64'd8);
    check_blit(1, "b_corner", 1, 156, 118, COL_WHITE, COL_GREEN, s, d);

    for (int r = 0; r < 6; r++) begin
      sel = $urandom_range(0, 3);
      x0 = $urandom_range(0, 159);
      y0 = $urandom_range(0, 119);
      fg = $urandom_range(0, 7);
      bg = $urandom_range(0, 7);
      start_blit(1, sel, x0, y0, fg, bg, 0, s);
      wait_done(1, 200, d);
      check_blit(1, $sformatf("b_rand%0d", r), sel, x0, y0, fg, bg, s, d);
      sel = $urandom_range(0, 3);
      start_blit(2, sel, x0, y0, fg, bg, 0, s);
      wait_done(2, 200, d);
      check_blit(2, $sformatf("c_rand%0d", r), sel, x0, y0, fg, bg, s, d);
    end

    // mid-scan start/input changes ignored; held start re-accepted after DONE
    start_blit(1, 2, 20, 30, COL_GREEN, COL_WHITE, 0, s);
    repeat (5) @(posedge CLOCK_50);
    #1;
    chk("b_mid addr5", 64'(b_addr), 64'd5);
    set_in(1, 0, 100, 100, COL_BLACK, COL_BLACK, 1'b1);
    @(posedge CLOCK_50);
    #1;
    set_start(1, 1'b0);
    chk("b_mid busy", 64'(b_busy), 64'd1);
    chk("b_mid addr6", 64'(b_addr), 64'd6);
    set_in(1, 1, 150, 117, COL_WHITE, COL_GREEN, 1'b1);
    wait_done(1, 200, d);
    check_blit(1, "b_mid", 2, 20, 30, COL_GREEN, COL_WHITE, s, d);
    @(posedge CLOCK_50);
    #1;
    s2 = cyc;
    set_start(1, 1'b0);
    chk("b2b start_cycle", 64'(s2), 64'(d + 2));
    chk("b2b busy", 64'(b_busy), 64'd1);
    chk("b2b addr0", 64'(b_addr), 64'd0);
    wait_done(1, 200, d2);
    check_blit(1, "b_b2b", 1, 150, 117, COL_WHITE, COL_GREEN, s2, d2);

    // transparent background with an all-ones ROM
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 32; j++) c_mem[i][j] = 1'b1;
    start_blit(2, 1, 10, 10, COL_GREEN, COL_WHITE, 0, s);
    wait_done(2, 200, d);
    chk("c_ones zero_plots", 64'(c_obs.size()), 64'd0);
    check_blit(2, "c_ones", 1, 10, 10, COL_GREEN, COL_WHITE, s, d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
